// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the Tang Nano 9K display counters.
// Segment byte layout: bit7 = a ... bit1 = g, bit0 = dp, active-high.
package seg7_pkg;

  localparam int CLK_HZ = 27_000_000;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int SEG_DP_BIT = 0;

  // Force the decimal point of a glyph to the given state.
  function automatic logic [7:0] seg_dp(input logic [7:0] s, input logic dp);
    logic [7:0] r;
    r = s;
    r[SEG_DP_BIT] = dp;
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to 7-segment glyph; blank forces all segments off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] seg
);

  // Glyph lookup; non-BCD codes show nothing, dp is always off.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
    seg = seg_dp(seg, 1'b0);
  end

endmodule

// File: rtl/seg_counter_mux.sv
// N-digit BCD up/down counter with a multiplexed common-anode 7-seg scan.
// Each digit has its own decoder; the scan just selects a ready glyph.
module seg_counter_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 27_000_000,
  parameter int SCAN_DIV = 27_000,
  parameter int BLANK_LZ = 1
) (
  input  logic              i_clk,
  input  logic              w_rst,
  input  logic              i_en,
  input  logic              i_up,
  input  logic              i_clr,
  output logic [7:0]        o_seg,
  output logic [DIGITS-1:0] o_dig,
  output logic              o_tick,
  output logic              o_wrap
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TW-1:0]            tick_cnt;
  logic                     step;
  logic [DIGITS-1:0][3:0]   dig, dig_nxt;
  logic                     cy;
  logic                     wrap_nxt;
  logic [SW-1:0]            scan_cnt;
  logic [IW-1:0]            idx;
  logic                     zero_above;
  logic [DIGITS-1:0]        lz, blank;
  logic [DIGITS-1:0][7:0]   glyph;

  // Clear wins over a step, so a step only fires on an enabled, uncleared terminal count.
  assign step = i_en && !i_clr && (tick_cnt == TW'(TICK_DIV - 1));

  // Ripple carry/borrow through the digit chain; a carry out of the top digit is a wrap.
  always_comb begin
    dig_nxt = dig;
    cy      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cy) begin
        if (i_up) begin
          if (dig[i] == 4'd9) dig_nxt[i] = 4'd0;
          else begin
            dig_nxt[i] = dig[i] + 4'd1;
            cy         = 1'b0;
          end
        end else begin
          if (dig[i] == 4'd0) dig_nxt[i] = 4'd9;
          else begin
            dig_nxt[i] = dig[i] - 4'd1;
            cy         = 1'b0;
          end
        end
      end
    end
    wrap_nxt = cy;
  end

  // lz[i]: digit i and every digit above it are zero.
  always_comb begin
    lz         = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (dig[i] == 4'd0);
      lz[i]      = zero_above;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign blank[g] = (BLANK_LZ != 0) && (g != 0) && lz[g];
    seg7_decode u_dec (
      .bcd   (dig[g]),
      .blank (blank[g]),
      .seg   (glyph[g])
    );
  end

  // Step prescaler: frozen by i_en low, zeroed by i_clr.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst)                                 tick_cnt <= '0;
    else if (i_clr)                            tick_cnt <= '0;
    else if (i_en) begin
      if (tick_cnt == TW'(TICK_DIV - 1))       tick_cnt <= '0;
      else                                     tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Counter value: clear first, then the step.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst)       dig <= '0;
    else if (i_clr)  dig <= '0;
    else if (step)   dig <= dig_nxt;
  end

  // Event pulses land in the cycle after the step cycle.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      o_tick <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      o_tick <= step;
      o_wrap <= step & wrap_nxt;
    end
  end

  // Free-running scan: dwell SCAN_DIV cycles per digit, LSD first.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Digit select and glyph registered together from the same idx so they never skew.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      o_dig <= ~DIGITS'(1);
      o_seg <= SEG_0;
    end else begin
      o_dig <= ~(DIGITS'(1) << idx);
      o_seg <= glyph[idx];
    end
  end

endmodule

// File: doc/seg_counter_mux.md
Name: seg_counter_mux

Overview:
- Parametrised N-digit BCD up/down counter with a time-multiplexed common-anode 7-segment scan driver.
- Successor to the single-digit 0-9 seconds counter on the Tang Nano 9K (27 MHz) board.
- Adds multi-digit carry/borrow, direction, enable, clear, leading-zero blanking and wrap/step event outputs.
- Sits between board buttons/switches and the 7-seg header pins.

Parameters:
- DIGITS, 4, number of BCD digits and digit-select lines (1..8).
- TICK_DIV, 27_000_000, i_clk cycles per count step (1 s at 27 MHz); must be ≥2.
- SCAN_DIV, 27_000, i_clk cycles per digit dwell (1 ms); must be ≥2.
- BLANK_LZ, 1, 1 = blank leading zeros on digits above digit 0.
- Derived widths: TW = $clog2(TICK_DIV), SW = $clog2(SCAN_DIV), IW = max(1, $clog2(DIGITS)).

Ports:
- i_clk  in  1  system clock.
- w_rst  in  1  reset, asynchronous, active-high.
- i_en  in  1  count enable; low freezes prescaler and value.
- i_up  in  1  1 = count up, 0 = count down; sampled on the step cycle.
- i_clr  in  1  synchronous clear of value and tick prescaler.
- o_seg  out  8  segments, active-high, bit7 = a … bit1 = g, bit0 = dp (dp always 0).
- o_dig  out  DIGITS  digit select, active-low, one-hot-low; bit0 = least significant digit.
- o_tick  out  1  one-cycle pulse when the value changes.
- o_wrap  out  1  one-cycle pulse on full-range wrap (coincident with o_tick).

Behaviour:
- Reset: clock i_clk, reset w_rst, asynchronous, active-high.
  - Tick prescaler = 0, scan prescaler = 0, all digits = 0, scan index = 0.
  - o_dig = all ones with bit0 = 0.
  - o_seg = 8'b11111100 (glyph "0").
  - o_tick = 0, o_wrap = 0.
- Tick prescaler, while i_en = 1 and i_clr = 0:
  - Counts 0..TICK_DIV-1; the cycle where it equals TICK_DIV-1 is the step cycle.
  - On the step cycle it returns to 0.
  - i_en = 0: prescaler and value hold; no step.
- Step up:
  - Digit 0 increments; a digit at 9 becomes 0 and carries to the next digit.
  - All 9s → all 0s, and o_wrap pulses.
- Step down:
  - Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
  - All 0s → all 9s, and o_wrap pulses.
- Step latency: the value updates on the clock edge ending the step cycle; o_tick (and o_wrap) are high for exactly the following cycle.
- i_clr:
  - Has priority over the step.
  - On the next edge, value = 0 and tick prescaler = 0; no o_tick and no o_wrap.
  - Scan logic is unaffected.
- Digit values are always 0..9; any non-BCD internal value is unreachable by construction.
- Scan prescaler:
  - Free-runs 0..SCAN_DIV-1, independent of i_en and i_clr.
  - At terminal count the scan index advances idx → idx+1, with DIGITS-1 → 0.
- Outputs are registered from the current idx and the current digit values, so o_dig and o_seg change on the same edge and are never misaligned:
  - o_dig: bit idx = 0, all other bits = 1.
  - o_seg = decode(digit[idx]), updated every cycle, so a value change is visible within 1 cycle while that digit is scanned.
- Blanking: when BLANK_LZ = 1, idx > 0, and digits idx..DIGITS-1 are all 0, o_seg = 8'h00. Digit 0 is never blanked.
- Glyph table, 0-9: FC 60 DA F2 66 B6 BE E0 FE F6.
- DIGITS = 1: idx is constant 0, o_dig = 1'b0.
- w_rst mid-count or mid-scan returns every register to its reset value immediately, without waiting for a clock edge.

Decomposition:
- Shared package seg7_pkg:
  - Glyph constants SEG_0..SEG_9 and SEG_BLANK.
  - Function/constant for the dp bit position.
  - Board constant CLK_HZ = 27_000_000.
- One sub-module, seg7_decode:
  - Combinational, 4-bit BCD + blank → 8-bit segments.
  - Shared with existing single-digit counters.
- Remaining logic (prescalers, BCD chain, scan, output registers) lives in seg_counter_mux.

Test Plan:
- All tests use DIGITS = 4, TICK_DIV = 4, SCAN_DIV = 2, BLANK_LZ = 1.
- Reset and hold: assert w_rst between edges → o_dig = 4'b1110, o_seg = FC immediately; release with i_en = 0 for 100 cycles → value stays 0000, o_tick never 1.
- Up count and carry: i_en = 1, i_up = 1 from 0009 → after the next step the value is 0010, o_tick pulses 1 cycle, o_wrap = 0; scan shows digit1 = 60 and digit0 = FC; digits 2 and 3 show 00 (blanked).
- Up wrap: preload to 9999 by counting down one step from 0000 → that step pulses o_wrap; one up-step → value 0000, o_tick and o_wrap both high for the same single cycle.
- Down borrow: from 0100, i_up = 0, one step → 0099; digit2 blanked (00), digit1 and digit0 = F6.
- Clear priority: assert i_clr exactly on a step cycle → next cycle value = 0000, no o_tick; next step occurs 4 cycles after i_clr deasserts.
- Scan order: observe 16 cycles → o_dig sequence 1110, 1101, 1011, 0111 repeating, each held 2 cycles; o_seg always matches the active digit in the same cycle; no cycle with two digits low.
